// File: rtl/dmadd_pkg.sv
// Shared types and engine instruction encodings for the DMADD command sequencer.
package dmadd_pkg;

    localparam logic [1:0] INSN_MIN  = 2'b00;
    localparam logic [1:0] INSN_MAX  = 2'b01;
    localparam logic [1:0] INSN_MADD = 2'b10;
    localparam logic [1:0] INSN_NOP  = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_INIT,
        ST_LOAD,
        ST_RUN,
        ST_FIN
    } state_t;

    typedef struct packed {
        logic [3:0] index;
        logic [3:0] data;
    } cmd_pair_t;

endpackage

// File: rtl/dmadd_cmd_fifo.sv
// Synchronous command FIFO; pointers carry an extra MSB to tell full from empty.
module dmadd_cmd_fifo
    import dmadd_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push_i,
    input  cmd_pair_t wdata_i,
    input  logic      pop_i,
    output cmd_pair_t rdata_o,
    output logic      full_o,
    output logic      empty_o,
    output logic      full_d_o
);

    localparam int AW = $clog2(DEPTH);

    cmd_pair_t   mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        push_ok, pop_ok;

    function automatic logic ptr_full(input logic [AW:0] w, input logic [AW:0] r);
        return (w[AW] != r[AW]) && (w[AW-1:0] == r[AW-1:0]);
    endfunction

    assign full_o   = ptr_full(wr_ptr_q, rd_ptr_q);
    assign empty_o  = (wr_ptr_q == rd_ptr_q);
    assign push_ok  = push_i && !full_o;
    assign pop_ok   = pop_i && !empty_o;
    assign wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
    assign rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_ok};
    // Look-ahead full lets the sequencer register in_ready for the next cycle.
    assign full_d_o = ptr_full(wr_ptr_d, rd_ptr_d);
    assign rdata_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/dmadd_sequencer.sv
// Buffers (index, data) pairs and replays them to the DMADD engine as
// reset / init / load / run, with every output registered.
//
//   state | meaning
//   IDLE  | accept pairs, engine pins at no-op
//   CLEAR | one cycle of engine reset
//   INIT  | one init cycle with insn = mode (MIN/MAX only)
//   LOAD  | one buffered pair per cycle onto the engine pins
//   RUN   | run held high for RUN_CYCLES cycles
//   FIN   | done pulse, back to IDLE
module dmadd_sequencer
    import dmadd_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int RUN_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_index,
    input  logic [3:0] in_data,
    input  logic       start,
    input  logic [1:0] mode,
    output logic       busy,
    output logic       done,
    output logic       eng_rst_n,
    output logic [3:0] eng_index,
    output logic [3:0] eng_data,
    output logic [1:0] eng_insn,
    output logic       eng_load,
    output logic       eng_run
);

    localparam int CW = $clog2(RUN_CYCLES + 1);

    state_t          state_q;
    logic [1:0]      mode_q;
    logic [CW-1:0]   run_cnt_q;
    logic            in_ready_q, busy_q, done_q, eng_rst_n_q;
    logic [3:0]      eng_index_q, eng_data_q;
    logic [1:0]      eng_insn_q;
    logic            eng_load_q, eng_run_q;

    logic            push, pop;
    logic            fifo_full, fifo_empty, fifo_full_d;
    cmd_pair_t       head;

    assign push = in_valid && in_ready_q && !fifo_full;

    always_comb begin
        pop = 1'b0;
        case (state_q)
            ST_CLEAR:         pop = (mode_q == INSN_MADD) && !fifo_empty;
            ST_INIT, ST_LOAD: pop = !fifo_empty;
            default:          pop = 1'b0;
        endcase
    end

    dmadd_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_i   (push),
        .wdata_i  ({in_index, in_data}),
        .pop_i    (pop),
        .rdata_o  (head),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty),
        .full_d_o (fifo_full_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mode_q      <= INSN_MIN;
            run_cnt_q   <= '0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            eng_rst_n_q <= 1'b0;
            eng_index_q <= 4'd0;
            eng_data_q  <= 4'd0;
            eng_insn_q  <= INSN_NOP;
            eng_load_q  <= 1'b1;
            eng_run_q   <= 1'b1;
        end else begin
            // Outputs describe the state being entered; no-op pattern unless overridden.
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            eng_rst_n_q <= 1'b1;
            eng_index_q <= 4'd0;
            eng_data_q  <= 4'd0;
            eng_insn_q  <= INSN_NOP;
            eng_load_q  <= 1'b1;
            eng_run_q   <= 1'b1;
            case (state_q)
                ST_IDLE: begin
                    if (start && (mode != INSN_NOP)) begin
                        mode_q      <= mode;
                        state_q     <= ST_CLEAR;
                        eng_rst_n_q <= 1'b0;
                    end else begin
                        busy_q     <= 1'b0;
                        in_ready_q <= !fifo_full_d;
                    end
                end
                ST_CLEAR, ST_INIT, ST_LOAD: begin
                    if ((state_q == ST_CLEAR) && (mode_q != INSN_MADD)) begin
                        state_q    <= ST_INIT;
                        eng_run_q  <= 1'b0;
                        eng_load_q <= 1'b0;
                        eng_insn_q <= mode_q;
                    end else if (!fifo_empty) begin
                        state_q     <= ST_LOAD;
                        eng_run_q   <= 1'b0;
                        eng_load_q  <= 1'b1;
                        eng_insn_q  <= mode_q;
                        eng_index_q <= head.index;
                        eng_data_q  <= head.data;
                    end else begin
                        state_q    <= ST_RUN;
                        run_cnt_q  <= CW'(RUN_CYCLES - 1);
                        eng_load_q <= 1'b0;
                        eng_insn_q <= mode_q;
                    end
                end
                ST_RUN: begin
                    if (run_cnt_q == '0) begin
                        state_q <= ST_FIN;
                        done_q  <= 1'b1;
                    end else begin
                        run_cnt_q  <= run_cnt_q - 1'b1;
                        eng_load_q <= 1'b0;
                        eng_insn_q <= mode_q;
                    end
                end
                ST_FIN: begin
                    state_q    <= ST_IDLE;
                    busy_q     <= 1'b0;
                    in_ready_q <= !fifo_full_d;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign eng_rst_n = eng_rst_n_q;
    assign eng_index = eng_index_q;
    assign eng_data  = eng_data_q;
    assign eng_insn  = eng_insn_q;
    assign eng_load  = eng_load_q;
    assign eng_run   = eng_run_q;

endmodule

// File: tb/tb_dmadd_sequencer.sv
// Randomized bench for dmadd_sequencer: a queue model builds the expected
// per-cycle pin trace of each operation and every cycle is compared.
module tb_dmadd_sequencer;

    localparam int FIFO_DEPTH = 8;
    localparam int RUN_CYCLES = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_index = 4'd0;
    logic [3:0] in_data = 4'd0;
    logic       start = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       busy, done, eng_rst_n, eng_load, eng_run;
    logic [3:0] eng_index, eng_data;
    logic [1:0] eng_insn;

    int         n_vec = 0;
    int         n_err = 0;
    int         op_n = 0;
    logic [7:0] mq[$];

    always #5 clk = ~clk;

    dmadd_sequencer #(.FIFO_DEPTH(FIFO_DEPTH), .RUN_CYCLES(RUN_CYCLES)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_index  (in_index),
        .in_data   (in_data),
        .start     (start),
        .mode      (mode),
        .busy      (busy),
        .done      (done),
        .eng_rst_n (eng_rst_n),
        .eng_index (eng_index),
        .eng_data  (eng_data),
        .eng_insn  (eng_insn),
        .eng_load  (eng_load),
        .eng_run   (eng_run)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] outvec();
        return {busy, done, in_ready, eng_rst_n, eng_run, eng_load,
                eng_insn, eng_index, eng_data};
    endfunction

    function automatic logic [15:0] mk(input logic b, input logic d, input logic r,
                                       input logic rn, input logic ru, input logic lo,
                                       input logic [1:0] ins, input logic [3:0] ix,
                                       input logic [3:0] dt);
        return {b, d, r, rn, ru, lo, ins, ix, dt};
    endfunction

    function automatic logic [15:0] idle_vec();
        logic rdy;
        rdy = (mq.size() < FIFO_DEPTH);
        return mk(1'b0, 1'b0, rdy, 1'b1, 1'b1, 1'b1, 2'b11, 4'd0, 4'd0);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset(input int n);
        rst = 1'b1;
        repeat (n) begin
            tick();
            chk("in_reset", outvec(), mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'b11, 4'd0, 4'd0));
        end
        rst = 1'b0;
        mq.delete();
        tick();
        chk("post_reset", outvec(), idle_vec());
    endtask

    task automatic push_pair(input logic [7:0] pr);
        logic rdy;
        rdy = (mq.size() < FIFO_DEPTH);
        in_valid = 1'b1;
        in_index = pr[7:4];
        in_data  = pr[3:0];
        chk("in_ready", {15'd0, in_ready}, {15'd0, rdy});
        tick();
        in_valid = 1'b0;
        if (rdy) mq.push_back(pr);
        chk("idle_push", outvec(), idle_vec());
    endtask

    task automatic do_op(input logic [1:0] m, input logic psame, input logic [7:0] pr,
                         input int noise_at, input int rst_at);
        logic [15:0] tr[$];
        logic        rdy;
        op_n++;
        rdy      = (mq.size() < FIFO_DEPTH);
        start    = 1'b1;
        mode     = m;
        in_valid = psame;
        in_index = pr[7:4];
        in_data  = pr[3:0];
        chk("ready_at_start", {15'd0, in_ready}, {15'd0, rdy});
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
        if (psame && rdy) mq.push_back(pr);
        if (m == 2'b11) begin
            chk("reserved_start", outvec(), idle_vec());
            return;
        end
        tr.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b11, 4'd0, 4'd0));
        if (m != 2'b10)
            tr.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, m, 4'd0, 4'd0));
        foreach (mq[i])
            tr.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, m, mq[i][7:4], mq[i][3:0]));
        repeat (RUN_CYCLES)
            tr.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, m, 4'd0, 4'd0));
        tr.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'b11, 4'd0, 4'd0));
        mq.delete();
        tr.push_back(idle_vec());
        for (int k = 0; k < tr.size(); k++) begin
            chk($sformatf("op%0d_c%0d", op_n, k), outvec(), tr[k]);
            if (k == rst_at) begin
                apply_reset(2);
                return;
            end
            if (k == noise_at && k < tr.size() - 1) begin
                start    = 1'b1;
                mode     = 2'($urandom);
                in_valid = 1'b1;
                in_index = 4'($urandom);
                in_data  = 4'($urandom);
            end
            tick();
            start    = 1'b0;
            in_valid = 1'b0;
        end
    endtask

    initial begin
        apply_reset(2);

        push_pair({4'd5, 4'($urandom)});
        push_pair({4'd9, 4'($urandom)});
        do_op(2'b00, 1'b0, 8'h00, -1, -1);

        push_pair(8'h34);
        push_pair(8'h72);
        do_op(2'b10, 1'b0, 8'h00, -1, -1);

        for (int i = 0; i < 9; i++) push_pair(8'($urandom));
        do_op(2'b10, 1'b0, 8'h00, 12, -1);

        push_pair(8'h00);
        push_pair(8'h00);
        do_op(2'b11, 1'b1, 8'hA5, -1, -1);
        do_op(2'b01, 1'b0, 8'h00, 5, -1);

        for (int i = 0; i < 5; i++) push_pair(8'($urandom));
        do_op(2'b00, 1'b0, 8'h00, -1, 3);
        do_op(2'b01, 1'b0, 8'h00, -1, -1);

        push_pair(8'h1E);
        do_op(2'b10, 1'b1, 8'h0F, -1, -1);

        for (int it = 0; it < 25; it++) begin
            int np, nat, rat;
            np  = int'($urandom_range(0, 10));
            nat = int'($urandom_range(0, 40));
            rat = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 20)) : -1;
            for (int j = 0; j < np; j++) push_pair(8'($urandom));
            do_op(2'($urandom), 1'($urandom), 8'($urandom), nat, rat);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
